// File: rtl/fsm_pkg.sv
// Shared types and constants for the go/done dispatcher and worker blocks.
package fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERROR  = 3'd5
  } dispatch_state_t;

  localparam int WORKER_LEN          = 16;
  localparam int DEF_TIMEOUT_CYCLES  = 32;
  localparam int DEF_GAP_CYCLES      = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fsm_job_dispatcher_if.sv
// Host/worker-facing signal bundle of the job dispatcher.
interface fsm_job_dispatcher_if #(
  parameter int JOB_CNT_W = 8
);
  logic                 start;
  logic [JOB_CNT_W-1:0] num_jobs;
  logic                 go;
  logic                 done_in;
  logic                 busy;
  logic [JOB_CNT_W-1:0] jobs_done;
  logic                 all_done;
  logic                 timeout_err;

  modport master (
    output start, num_jobs, done_in,
    input  go, busy, jobs_done, all_done, timeout_err
  );

  modport slave (
    input  start, num_jobs, done_in,
    output go, busy, jobs_done, all_done, timeout_err
  );
endinterface

// File: rtl/fsm_watchdog.sv
// Cycle watchdog: counts enabled cycles since clear, flags the last allowed one.
module fsm_watchdog
  import fsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Holds at LAST so the count can never wrap back to a "fresh" value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/fsm_job_dispatcher.sv
// Issues one go pulse per job of a batch, waits for done with a watchdog,
// and spaces jobs by a fixed idle gap.
module fsm_job_dispatcher
  import fsm_pkg::*;
#(
  parameter int JOB_CNT_W      = 8,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  fsm_job_dispatcher_if.slave   bus
);

  localparam int            GW       = cnt_width(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  dispatch_state_t      state, state_nxt;
  logic [JOB_CNT_W-1:0] remaining;
  logic [JOB_CNT_W-1:0] jobs_done_q;
  logic                 timeout_q;
  logic [GW-1:0]        gap_cnt;
  logic                 wd_expired;

  fsm_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_ISSUE),
    .enable  (state == ST_WAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.num_jobs != '0) ? ST_ISSUE : ST_FINISH;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the watchdog's last cycle still counts.
        if (bus.done_in) begin
          if (remaining == JOB_CNT_W'(1)) begin
            state_nxt = ST_FINISH;
          end else begin
            state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_ISSUE;
          end
        end else if (wd_expired) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      ST_ERROR:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining   <= '0;
      jobs_done_q <= '0;
      timeout_q   <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            remaining   <= bus.num_jobs;
            jobs_done_q <= '0;
            timeout_q   <= 1'b0;
          end
        end
        ST_WAIT: begin
          gap_cnt <= '0;
          if (bus.done_in) begin
            remaining <= remaining - JOB_CNT_W'(1);
            if (jobs_done_q != '1) begin
              jobs_done_q <= jobs_done_q + JOB_CNT_W'(1);
            end
          end else if (wd_expired) begin
            // Raised on entry to ERROR so the flag is visible in that cycle.
            timeout_q <= 1'b1;
          end
        end
        ST_GAP: gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

  assign bus.go          = (state == ST_ISSUE);
  assign bus.all_done    = (state == ST_FINISH);
  assign bus.busy        = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_GAP);
  assign bus.jobs_done   = jobs_done_q;
  assign bus.timeout_err = timeout_q;

endmodule
